// File: rtl/state_snapshot_decoder_if.sv
// Snapshot strobes/data, query index and decoded results of the decoder.
// master: drives strobes, packed vectors and idx_i; slave: the decoder.
interface state_snapshot_decoder_if #(
  parameter int NUM_VARS         = 8,
  parameter int NUM_LVLS         = 8,
  parameter int WIDTH_LVL        = 16,
  parameter int WIDTH_BIN_ID     = 10,
  parameter int WIDTH_VAR_STATES = 19,
  parameter int WIDTH_LVL_STATES = 11
);
  logic                                 snap_vs_i;
  logic [NUM_VARS*WIDTH_VAR_STATES-1:0] vs_i;
  logic                                 snap_ls_i;
  logic [NUM_LVLS*WIDTH_LVL_STATES-1:0] ls_i;
  logic                                 snap_val_i;
  logic [NUM_VARS*3-1:0]                val_i;
  logic                                 snap_lit_i;
  logic [NUM_VARS*2-1:0]                lit_i;
  logic [7:0]                           idx_i;

  logic [1:0]              q_value_o;
  logic                    q_implied_o;
  logic [WIDTH_LVL-1:0]    q_var_lvl_o;
  logic [WIDTH_BIN_ID-1:0] q_bin_o;
  logic                    q_dcd_o;
  logic [1:0]              q_lit_o;
  logic [NUM_VARS-1:0]     assigned_mask_o;
  logic [NUM_VARS-1:0]     implied_mask_o;
  logic [7:0]              num_assigned_o;
  logic [WIDTH_LVL-1:0]    max_lvl_o;
  logic [NUM_VARS-1:0]     pos_mask_o;
  logic [NUM_VARS-1:0]     neg_mask_o;
  logic [7:0]              num_lits_o;
  logic                    err_o;
  logic                    vs_valid_o;
  logic                    ls_valid_o;
  logic                    cl_valid_o;

  modport master (
    output snap_vs_i, vs_i, snap_ls_i, ls_i,
    output snap_val_i, val_i, snap_lit_i, lit_i, idx_i,
    input  q_value_o, q_implied_o, q_var_lvl_o,
    input  q_bin_o, q_dcd_o, q_lit_o,
    input  assigned_mask_o, implied_mask_o,
    input  num_assigned_o, max_lvl_o,
    input  pos_mask_o, neg_mask_o, num_lits_o,
    input  err_o, vs_valid_o, ls_valid_o, cl_valid_o
  );

  modport slave (
    input  snap_vs_i, vs_i, snap_ls_i, ls_i,
    input  snap_val_i, val_i, snap_lit_i, lit_i, idx_i,
    output q_value_o, q_implied_o, q_var_lvl_o,
    output q_bin_o, q_dcd_o, q_lit_o,
    output assigned_mask_o, implied_mask_o,
    output num_assigned_o, max_lvl_o,
    output pos_mask_o, neg_mask_o, num_lits_o,
    output err_o, vs_valid_o, ls_valid_o, cl_valid_o
  );
endinterface

// File: rtl/state_snapshot_decoder.sv
// Captures var/level/clause snapshots and decodes fields and summary stats.
// Ports: clk, rst (async high), bus (slave): strobes, vectors, idx, results.
module state_snapshot_decoder #(
  parameter int NUM_VARS         = 8,
  parameter int NUM_LVLS         = 8,
  parameter int WIDTH_LVL        = 16,
  parameter int WIDTH_BIN_ID     = 10,
  parameter int WIDTH_VAR_STATES = 19,
  parameter int WIDTH_LVL_STATES = 11
) (
  input logic clk,
  input logic rst,
  state_snapshot_decoder_if.slave bus
);
  localparam int WV = WIDTH_VAR_STATES;
  localparam int WL = WIDTH_LVL_STATES;

  logic [NUM_VARS*WV-1:0] vs_q, vs_d;
  logic [NUM_LVLS*WL-1:0] ls_q, ls_d;
  logic [NUM_VARS*2-1:0]  cl_q, cl_d;
  logic vs_valid_q, vs_valid_d;
  logic ls_valid_q, ls_valid_d;
  logic cl_valid_q, cl_valid_d;
  logic err_q, err_d;

  // Implied bits of val_i play no part in clause derivation.
  logic [NUM_VARS-1:0] unused_val_hi;

  always_comb begin
    unused_val_hi = '0;
    for (int i = 0; i < NUM_VARS; i++)
      unused_val_hi[i] = bus.val_i[3*i+2];
  end

  always_comb begin
    vs_d       = vs_q;
    ls_d       = ls_q;
    cl_d       = cl_q;
    vs_valid_d = vs_valid_q;
    ls_valid_d = ls_valid_q;
    cl_valid_d = cl_valid_q;
    err_d      = err_q;

    if (bus.snap_vs_i) begin
      vs_d       = bus.vs_i;
      vs_valid_d = 1'b1;
      for (int i = 0; i < NUM_VARS; i++)
        if (bus.vs_i[i*WV+WIDTH_LVL +: 2] == 2'b11)
          err_d = 1'b1;
    end

    if (bus.snap_ls_i) begin
      ls_d       = bus.ls_i;
      ls_valid_d = 1'b1;
    end

    if (bus.snap_lit_i) begin
      cl_valid_d = 1'b1;
      for (int i = 0; i < NUM_VARS; i++) begin
        if (bus.lit_i[2*i +: 2] == 2'b11) begin
          cl_d[2*i +: 2] = 2'b00;
          err_d          = 1'b1;
        end else begin
          cl_d[2*i +: 2] = bus.lit_i[2*i +: 2];
        end
      end
    end else if (bus.snap_val_i) begin
      cl_valid_d = 1'b1;
      // A true var yields a negative literal and vice versa.
      for (int i = 0; i < NUM_VARS; i++) begin
        unique case (bus.val_i[3*i +: 2])
          2'b10:   cl_d[2*i +: 2] = 2'b01;
          2'b01:   cl_d[2*i +: 2] = 2'b10;
          2'b11: begin
            cl_d[2*i +: 2] = 2'b00;
            err_d          = 1'b1;
          end
          default: cl_d[2*i +: 2] = 2'b00;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q       <= '0;
      ls_q       <= '0;
      cl_q       <= '0;
      vs_valid_q <= 1'b0;
      ls_valid_q <= 1'b0;
      cl_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      vs_q       <= vs_d;
      ls_q       <= ls_d;
      cl_q       <= cl_d;
      vs_valid_q <= vs_valid_d;
      ls_valid_q <= ls_valid_d;
      cl_valid_q <= cl_valid_d;
      err_q      <= err_d;
    end
  end

  logic [NUM_VARS-1:0]  asg_mask, imp_mask;
  logic [7:0]           asg_cnt;
  logic [WIDTH_LVL-1:0] max_lvl;

  always_comb begin
    asg_mask = '0;
    imp_mask = '0;
    asg_cnt  = '0;
    max_lvl  = '0;
    for (int i = 0; i < NUM_VARS; i++) begin
      // Odd parity of value[1:0] means 01 or 10, i.e. legally assigned.
      if (^vs_q[i*WV+WIDTH_LVL +: 2]) begin
        asg_mask[i] = 1'b1;
        imp_mask[i] = vs_q[i*WV+WIDTH_LVL+2];
        asg_cnt     = asg_cnt + 8'd1;
        if (vs_q[i*WV +: WIDTH_LVL] > max_lvl)
          max_lvl = vs_q[i*WV +: WIDTH_LVL];
      end
    end
  end

  logic [NUM_VARS-1:0] pos_mask, neg_mask;
  logic [7:0]          lit_cnt;

  // Stored literals are never 11, so each bit alone identifies polarity.
  always_comb begin
    pos_mask = '0;
    neg_mask = '0;
    lit_cnt  = '0;
    for (int i = 0; i < NUM_VARS; i++) begin
      pos_mask[i] = cl_q[2*i+1];
      neg_mask[i] = cl_q[2*i];
      if (cl_q[2*i+1] | cl_q[2*i])
        lit_cnt = lit_cnt + 8'd1;
    end
  end

  logic [1:0]              q_value, q_lit;
  logic                    q_implied, q_dcd;
  logic [WIDTH_LVL-1:0]    q_var_lvl;
  logic [WIDTH_BIN_ID-1:0] q_bin;

  // Out-of-range indices match no slot and read zero.
  always_comb begin
    q_value   = '0;
    q_implied = 1'b0;
    q_var_lvl = '0;
    q_lit     = '0;
    q_bin     = '0;
    q_dcd     = 1'b0;
    for (int i = 0; i < NUM_VARS; i++) begin
      if (bus.idx_i == 8'(i)) begin
        q_value   = vs_q[i*WV+WIDTH_LVL +: 2];
        q_implied = vs_q[i*WV+WIDTH_LVL+2];
        q_var_lvl = vs_q[i*WV +: WIDTH_LVL];
        q_lit     = cl_q[2*i +: 2];
      end
    end
    for (int i = 0; i < NUM_LVLS; i++) begin
      if (bus.idx_i == 8'(i)) begin
        q_bin = ls_q[i*WL+1 +: WIDTH_BIN_ID];
        q_dcd = ls_q[i*WL];
      end
    end
  end

  assign bus.q_value_o       = q_value;
  assign bus.q_implied_o     = q_implied;
  assign bus.q_var_lvl_o     = q_var_lvl;
  assign bus.q_bin_o         = q_bin;
  assign bus.q_dcd_o         = q_dcd;
  assign bus.q_lit_o         = q_lit;
  assign bus.assigned_mask_o = asg_mask;
  assign bus.implied_mask_o  = imp_mask;
  assign bus.num_assigned_o  = asg_cnt;
  assign bus.max_lvl_o       = max_lvl;
  assign bus.pos_mask_o      = pos_mask;
  assign bus.neg_mask_o      = neg_mask;
  assign bus.num_lits_o      = lit_cnt;
  assign bus.err_o           = err_q;
  assign bus.vs_valid_o      = vs_valid_q;
  assign bus.ls_valid_o      = ls_valid_q;
  assign bus.cl_valid_o      = cl_valid_q;
endmodule

// File: tb/tb_state_snapshot_decoder.sv
// Directed bench: behavioural model feeds a scoreboard of expected outputs.
// Each step drives strobes/idx, pushes the expectation, compares after edge.
module tb_state_snapshot_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  state_snapshot_decoder_if bus ();

  state_snapshot_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] am, im, na, ml, pm, nm, nl;
    logic [31:0] err, vv, lv, cv;
    logic [31:0] qv, qi, ql, qb, qd, qlit;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  int mval[8];
  int mlvl[8];
  int mbin[8];
  int mdcd[8];
  int mlit[8];
  bit merr, mvv, mlv, mcv;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      mval[i] = 0; mlvl[i] = 0; mbin[i] = 0;
      mdcd[i] = 0; mlit[i] = 0;
    end
    merr = 0; mvv = 0; mlv = 0; mcv = 0;
  endfunction

  function automatic void model_capture(input bit sv, input bit sl,
                                        input bit sval, input bit slit);
    if (sv) begin
      mvv = 1;
      for (int i = 0; i < 8; i++) begin
        mval[i] = int'(bus.vs_i[i*19+16 +: 3]);
        mlvl[i] = int'(bus.vs_i[i*19 +: 16]);
        if (mval[i] % 4 == 3) merr = 1;
      end
    end
    if (sl) begin
      mlv = 1;
      for (int i = 0; i < 8; i++) begin
        mbin[i] = int'(bus.ls_i[i*11+1 +: 10]);
        mdcd[i] = int'(bus.ls_i[i*11]);
      end
    end
    if (slit) begin
      mcv = 1;
      for (int i = 0; i < 8; i++) begin
        int l = int'(bus.lit_i[2*i +: 2]);
        if (l == 3) begin mlit[i] = 0; merr = 1; end
        else mlit[i] = l;
      end
    end else if (sval) begin
      mcv = 1;
      for (int i = 0; i < 8; i++) begin
        int v = int'(bus.val_i[3*i +: 2]);
        if (v == 2) mlit[i] = 1;
        else if (v == 1) mlit[i] = 2;
        else begin
          mlit[i] = 0;
          if (v == 3) merr = 1;
        end
      end
    end
  endfunction

  function automatic exp_t model_expect(input logic [7:0] idx);
    exp_t e = '{default: '0};
    for (int i = 0; i < 8; i++) begin
      int v = mval[i] % 4;
      if (v == 1 || v == 2) begin
        e.am[i] = 1'b1;
        e.im[i] = ((mval[i] / 4) % 2) == 1;
        e.na = e.na + 1;
        if (mlvl[i] > int'(e.ml)) e.ml = mlvl[i];
      end
      if (mlit[i] == 2) e.pm[i] = 1'b1;
      if (mlit[i] == 1) e.nm[i] = 1'b1;
      if (mlit[i] != 0) e.nl = e.nl + 1;
    end
    e.err = 32'(merr);
    e.vv  = 32'(mvv);
    e.lv  = 32'(mlv);
    e.cv  = 32'(mcv);
    if (idx < 8) begin
      e.qv   = mval[idx] % 4;
      e.qi   = (mval[idx] / 4) % 2;
      e.ql   = mlvl[idx];
      e.qlit = mlit[idx];
      e.qb   = mbin[idx];
      e.qd   = mdcd[idx];
    end
    return e;
  endfunction

  task automatic compare(input string ph);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.sb_empty obs=0 exp=1", ph);
      return;
    end
    e = sb.pop_front();
    check({ph, ".assigned"}, 32'(bus.assigned_mask_o), e.am);
    check({ph, ".implied"},  32'(bus.implied_mask_o),  e.im);
    check({ph, ".num_asg"},  32'(bus.num_assigned_o),  e.na);
    check({ph, ".max_lvl"},  32'(bus.max_lvl_o),       e.ml);
    check({ph, ".pos"},      32'(bus.pos_mask_o),      e.pm);
    check({ph, ".neg"},      32'(bus.neg_mask_o),      e.nm);
    check({ph, ".num_lits"}, 32'(bus.num_lits_o),      e.nl);
    check({ph, ".err"},      32'(bus.err_o),           e.err);
    check({ph, ".vs_valid"}, 32'(bus.vs_valid_o),      e.vv);
    check({ph, ".ls_valid"}, 32'(bus.ls_valid_o),      e.lv);
    check({ph, ".cl_valid"}, 32'(bus.cl_valid_o),      e.cv);
    check({ph, ".q_value"},  32'(bus.q_value_o),       e.qv);
    check({ph, ".q_impl"},   32'(bus.q_implied_o),     e.qi);
    check({ph, ".q_vlvl"},   32'(bus.q_var_lvl_o),     e.ql);
    check({ph, ".q_bin"},    32'(bus.q_bin_o),         e.qb);
    check({ph, ".q_dcd"},    32'(bus.q_dcd_o),         e.qd);
    check({ph, ".q_lit"},    32'(bus.q_lit_o),         e.qlit);
  endtask

  task automatic step(input string ph, input bit sv, input bit sl,
                      input bit sval, input bit slit,
                      input logic [7:0] idx);
    bus.snap_vs_i  = sv;
    bus.snap_ls_i  = sl;
    bus.snap_val_i = sval;
    bus.snap_lit_i = slit;
    bus.idx_i      = idx;
    model_capture(sv, sl, sval, slit);
    sb.push_back(model_expect(idx));
    @(posedge clk);
    #1;
    bus.snap_vs_i  = 1'b0;
    bus.snap_ls_i  = 1'b0;
    bus.snap_val_i = 1'b0;
    bus.snap_lit_i = 1'b0;
    compare(ph);
  endtask

  task automatic do_reset(input string ph);
    rst = 1'b1;
    model_reset();
    #1;
    sb.push_back(model_expect(bus.idx_i));
    compare({ph, ".during"});
    @(posedge clk);
    #1;
    sb.push_back(model_expect(bus.idx_i));
    compare({ph, ".held"});
    rst = 1'b0;
  endtask

  task automatic set_var(input int i, input logic [2:0] v,
                         input logic [15:0] lvl);
    bus.vs_i[i*19 +: 19] = {v, lvl};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bus.snap_vs_i  = 1'b0;
    bus.snap_ls_i  = 1'b0;
    bus.snap_val_i = 1'b0;
    bus.snap_lit_i = 1'b0;
    bus.vs_i       = '0;
    bus.ls_i       = '0;
    bus.val_i      = '0;
    bus.lit_i      = '0;
    bus.idx_i      = '0;

    do_reset("rst0");
    step("idle", 0, 0, 0, 0, 8'd0);

    set_var(0, 3'b010, 16'd3);
    set_var(1, 3'b101, 16'd7);
    set_var(2, 3'b000, 16'd5);
    step("vs", 1, 0, 0, 0, 8'd1);
    check("plan.am", 32'(bus.assigned_mask_o), 32'h03);
    check("plan.im", 32'(bus.implied_mask_o), 32'h02);
    check("plan.na", 32'(bus.num_assigned_o), 32'd2);
    check("plan.ml", 32'(bus.max_lvl_o), 32'd7);
    check("plan.qv", 32'(bus.q_value_o), 32'h1);
    step("q_unasg_lvl", 0, 0, 0, 0, 8'd2);
    check("plan.unasg_lvl", 32'(bus.q_var_lvl_o), 32'd5);
    step("q_idx8", 0, 0, 0, 0, 8'd8);
    step("q_idx255", 0, 0, 0, 0, 8'd255);

    bus.ls_i[3*11 +: 11] = {10'd42, 1'b1};
    bus.ls_i[7*11 +: 11] = {10'd1023, 1'b0};
    step("ls", 0, 1, 0, 0, 8'd3);
    check("plan.bin", 32'(bus.q_bin_o), 32'd42);
    step("q_lvl9", 0, 0, 0, 0, 8'd9);
    check("plan.bin9", 32'(bus.q_bin_o), 32'd0);
    step("q_lvl7", 0, 0, 0, 0, 8'd7);

    bus.val_i = '0;
    bus.val_i[0 +: 3] = 3'b010;
    bus.val_i[3 +: 3] = 3'b001;
    bus.val_i[12 +: 3] = 3'b000;
    step("val", 0, 0, 1, 0, 8'd0);
    check("plan.neg", 32'(bus.neg_mask_o), 32'h01);
    check("plan.pos", 32'(bus.pos_mask_o), 32'h02);
    check("plan.nl", 32'(bus.num_lits_o), 32'd2);
    step("q_lit1", 0, 0, 0, 0, 8'd1);

    bus.lit_i = 16'hAAAA;
    step("prio", 0, 0, 1, 1, 8'd0);
    check("plan.prio_pos", 32'(bus.pos_mask_o), 32'hFF);
    check("plan.prio_nl", 32'(bus.num_lits_o), 32'd8);

    bus.lit_i = 16'hAABA;
    step("lit_ill", 0, 0, 0, 1, 8'd2);
    check("plan.ill_err", 32'(bus.err_o), 32'd1);
    bus.lit_i = 16'h5555;
    step("lit_clean", 0, 0, 0, 1, 8'd2);
    check("plan.sticky", 32'(bus.err_o), 32'd1);

    set_var(1, 3'b101, 16'd9);
    step("hold1", 1, 0, 0, 0, 8'd1);
    set_var(3, 3'b110, 16'd12);
    step("hold2", 1, 0, 0, 0, 8'd3);

    do_reset("rst_mid");
    step("post_rst", 0, 0, 0, 0, 8'd3);

    set_var(1, 3'b101, 16'd7);
    set_var(3, 3'b000, 16'd0);
    set_var(5, 3'b011, 16'd200);
    step("var_ill", 1, 0, 0, 0, 8'd0);
    check("plan.ill_am", 32'(bus.assigned_mask_o), 32'h03);
    check("plan.ill_ml", 32'(bus.max_lvl_o), 32'd7);

    do_reset("rst2");
    bus.val_i = '0;
    bus.val_i[9 +: 3]  = 3'b011;
    bus.val_i[18 +: 3] = 3'b110;
    set_var(5, 3'b000, 16'd0);
    step("all3", 1, 1, 1, 0, 8'd6);
    step("q_lvl3", 0, 0, 0, 0, 8'd3);

    do_reset("rst_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/state_snapshot_decoder.md
Name: state_snapshot_decoder

Overview:
- Debug/verification helper attached beside state_list in the SAT engine.
- Captures snapshots of three packed vectors: the variable-state vector, the level-state vector, and a clause vector (learnt clause, or one derived from variable values).
- Decodes per-index fields and computes summary statistics that benches and debug logic read through an index-addressed query port.

Parameters:
- NUM_VARS, 8, number of variable records and clause literal slots.
- NUM_LVLS, 8, number of level records.
- WIDTH_LVL, 16, level field width.
- WIDTH_BIN_ID, 10, bin id field width.
- WIDTH_VAR_STATES, 19, var record width; must equal 3+WIDTH_LVL.
- WIDTH_LVL_STATES, 11, level record width; must equal WIDTH_BIN_ID+1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- snap_vs_i  in  1  capture strobe for vs_i.
- vs_i  in  NUM_VARS*WIDTH_VAR_STATES  packed var records; record i at bits [i*WIDTH_VAR_STATES +: WIDTH_VAR_STATES].
- snap_ls_i  in  1  capture strobe for ls_i.
- ls_i  in  NUM_LVLS*WIDTH_LVL_STATES  packed level records, same indexing.
- snap_val_i  in  1  capture a clause derived from val_i.
- val_i  in  NUM_VARS*3  per-variable 3-bit values.
- snap_lit_i  in  1  capture a clause directly from lit_i.
- lit_i  in  NUM_VARS*2  per-variable 2-bit literals.
- idx_i  in  8  query index.
- q_value_o  out  2  value field of var[idx].
- q_implied_o  out  1  implied flag of var[idx].
- q_var_lvl_o  out  WIDTH_LVL  level of var[idx].
- q_bin_o  out  WIDTH_BIN_ID  bin id of lvl[idx].
- q_dcd_o  out  1  decided flag of lvl[idx].
- q_lit_o  out  2  clause literal [idx].
- assigned_mask_o  out  NUM_VARS  var i has value 01 or 10.
- implied_mask_o  out  NUM_VARS  var i is assigned and has the implied bit set.
- num_assigned_o  out  8  popcount of assigned_mask_o.
- max_lvl_o  out  WIDTH_LVL  max level over assigned vars; 0 if none.
- pos_mask_o / neg_mask_o  out  NUM_VARS each  clause literal 10 / 01.
- num_lits_o  out  8  popcount(pos|neg).
- err_o  out  1  sticky illegal-encoding flag.
- vs_valid_o / ls_valid_o / cl_valid_o  out  1 each  snapshot captured since reset.

Behaviour:
- Var record layout: {value[2:0], lvl[WIDTH_LVL-1:0]}.
  - value[1:0]: 00 unassigned, 01 false, 10 true, 11 illegal.
  - value[2]: implied (1) or decided (0).
- Level record layout: {bin_id, dcd}.
- Literal encoding: 00 absent, 01 negative, 10 positive, 11 illegal.
- Snapshot timing:
  - On a clk rising edge with a strobe high, the matching snapshot register loads and its valid flag sets.
  - All outputs are combinational from the snapshot registers, so results are visible the cycle after the strobe.
  - Latency is 1 cycle.
  - Strobes are level-sampled: holding a strobe high re-captures every cycle.
- Clause derived from values, per var:
  - true (10) -> literal 01.
  - false (01) -> literal 10.
  - unassigned -> 00.
  - illegal value -> 00, and err_o sets.
- If snap_val_i and snap_lit_i are both high, snap_lit_i wins.
- Illegal var value 11 is treated as unassigned: excluded from masks, counts and max_lvl, and sets err_o.
- An illegal captured literal 11 is stored as 00 and sets err_o.
- err_o sets on the capture edge and stays set until reset.
- Query port:
  - idx_i >= NUM_VARS returns zero for all var and literal query outputs.
  - idx_i >= NUM_LVLS returns zero for the level query outputs.
  - No wrap-around.
- An unassigned var with a nonzero lvl field still reports q_var_lvl_o as stored.
- Reset, including when asserted mid-operation, asynchronously clears all snapshots, valid flags and err_o.
  - All outputs read 0 during and after reset until the next capture.
- Independent strobes in the same cycle all capture.

Test Plan:
- Reset: assert rst mid-run after captures -> every output 0, all valid flags 0, err_o 0.
- Var snapshot:
  - Stimulus: var0={010,lvl 3}, var1={101,lvl 7}, var2={000,lvl 5}, others 0; pulse snap_vs_i.
  - Next cycle: assigned_mask=0000_0011, implied_mask=0000_0010, num_assigned=2, max_lvl=7.
  - Query: idx=1 -> q_value=01, q_implied=1, q_var_lvl=7.
- Level snapshot: lvl3={bin 42,dcd 1}; snap_ls_i; idx=3 -> q_bin=42, q_dcd=1; idx=9 -> q_bin=0, q_dcd=0.
- Clause from values: val var0=010, var1=001, var4=000; snap_val_i -> q_lit[0]=01, q_lit[1]=10, neg_mask=0000_0001, pos_mask=0000_0010, num_lits=2.
- Priority and errors:
  - snap_val_i and snap_lit_i together, lit_i=all 10 -> pos_mask=FF, num_lits=8.
  - Then lit slot 2=11 -> slot reads 00, err_o=1, and err_o remains 1 after further clean captures.
- Illegal value: var5 value 011 with lvl 200 -> excluded from assigned_mask, max_lvl unchanged, err_o=1.
